// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: op/sel codes and shared constants used by both decode and
// execute. Any change here changes the decode/execute contract.
package ex_stage_pkg;

  // alu_op codes (MIPS funct-style)
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;

  // alu_sel result classes
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational logic/shift unit.
//   op     - decoded alu_op; the op alone picks the function
//   src1   - operand 1; low log2(DATA_W) bits are the shift amount
//   src2   - operand 2; the value shifted for shift ops
//   result - function result, 0 for nop and unknown ops
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 8
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] result
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  logic            unused_src1_hi;

  assign shamt          = src1[SH_W-1:0];
  assign unused_src1_hi = ^src1[DATA_W-1:SH_W];

  always_comb begin
    result = '0;
    case (op)
      OP_OR:   result = src1 | src2;
      OP_AND:  result = src1 & src2;
      OP_XOR:  result = src1 ^ src2;
      OP_NOR:  result = ~(src1 | src2);
      OP_SLL:  result = src2 << shamt;
      OP_SRL:  result = src2 >> shamt;
      OP_SRA:  result = DATA_W'($signed(src2) >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
//   clk, rst        - clock, synchronous active-high reset
//   stall, flush    - hazard control from decode (flush beats stall)
//   alu_op..id_des_exist - decoded op and operands from decode
//   ex_des_*        - EX-stage result, combinational from ID/EX (forward bus 1)
//   mem_des_*       - registered EX/MEM result (forward bus 2, to MEM/WB)
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] id_src1,
  input  logic [DATA_W-1:0] id_src2,
  input  logic [ADDR_W-1:0] id_des_addr,
  input  logic              id_des_exist,
  output logic              ex_des_exist,
  output logic [ADDR_W-1:0] ex_des_addr,
  output logic [DATA_W-1:0] ex_des_data,
  output logic              mem_des_exist,
  output logic [ADDR_W-1:0] mem_des_addr,
  output logic [DATA_W-1:0] mem_des_data
);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [ADDR_W-1:0] addr;
    logic              exist;
  } idex_t;

  typedef struct packed {
    logic              exist;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exmem_t;

  idex_t             idex_d, idex_q;
  exmem_t            exmem_d, exmem_q;
  logic [DATA_W-1:0] alu_res;
  logic              sel_nop;

  ex_alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .op     (idex_q.op),
    .src1   (idex_q.src1),
    .src2   (idex_q.src2),
    .result (alu_res)
  );

  // sel only matters for nop: it kills both result and write. Otherwise the
  // op code governs, so sllv/srlv/srav with sel=logic still shift.
  assign sel_nop      = (idex_q.sel == SEL_NOP);
  assign ex_des_addr  = idex_q.addr;
  assign ex_des_data  = sel_nop ? '0 : alu_res;
  // $0 is hardwired zero: never forward or write it.
  assign ex_des_exist = idex_q.exist && !sel_nop && (idex_q.addr != NOP_REG_ADDR);

  always_comb begin
    idex_d  = idex_q;
    exmem_d = '{exist: ex_des_exist, addr: ex_des_addr, data: ex_des_data};
    if (rst || flush) begin
      idex_d  = '0;
      exmem_d = '0;
    end else if (stall) begin
      // ID/EX holds the stalled op; EX/MEM takes a bubble so it is not
      // written twice.
      exmem_d = '0;
    end else begin
      idex_d = '{op: alu_op, sel: alu_sel, src1: id_src1, src2: id_src2,
                 addr: id_des_addr, exist: id_des_exist};
    end
  end

  always_ff @(posedge clk) begin
    idex_q  <= idex_d;
    exmem_q <= exmem_d;
  end

  assign mem_des_exist = exmem_q.exist;
  assign mem_des_addr  = exmem_q.addr;
  assign mem_des_data  = exmem_q.data;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [7:0]  alu_op;
  logic [2:0]  alu_sel;
  logic [31:0] id_src1, id_src2;
  logic [4:0]  id_des_addr;
  logic        id_des_exist;
  logic        ex_des_exist, mem_des_exist;
  logic [4:0]  ex_des_addr, mem_des_addr;
  logic [31:0] ex_des_data, mem_des_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .alu_op(alu_op), .alu_sel(alu_sel), .id_src1(id_src1), .id_src2(id_src2),
    .id_des_addr(id_des_addr), .id_des_exist(id_des_exist),
    .ex_des_exist(ex_des_exist), .ex_des_addr(ex_des_addr), .ex_des_data(ex_des_data),
    .mem_des_exist(mem_des_exist), .mem_des_addr(mem_des_addr), .mem_des_data(mem_des_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instruction is turned into its expected visible record when it is
  // issued; the record then sits in "EX" and moves on to "MEM".
  typedef struct packed {
    logic        e;
    logic [4:0]  a;
    logic [31:0] d;
  } rec_t;

  rec_t m_ex, m_mem;
  bit   model_on = 0;

  function automatic logic [31:0] m_alu(input logic [7:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned n;
    logic        sgn;
    n   = a[4:0];
    sgn = b[31];
    case (op)
      8'h25: return a | b;
      8'h24: return a & b;
      8'h26: return a ^ b;
      8'h27: return ~(a | b);
      8'h7C: return b << n;
      8'h02: return b >> n;
      8'h03: return (b >> n) | (sgn ? ~(32'hFFFF_FFFF >> n) : 32'h0);
      default: return 32'h0;
    endcase
  endfunction

  function automatic rec_t issue(input logic [7:0] op, input logic [2:0] sel,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] addr, input logic ex);
    rec_t r;
    r.a = addr;
    r.e = ex && (sel != 3'd0) && (addr != 5'd0);
    r.d = (sel == 3'd0) ? 32'h0 : m_alu(op, a, b);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) model_on <= 1'b1;
    if (rst || flush) begin
      m_ex  <= '0;
      m_mem <= '0;
    end else if (stall) begin
      m_mem <= '0;
    end else begin
      m_mem <= m_ex;
      m_ex  <= issue(alu_op, alu_sel, id_src1, id_src2, id_des_addr, id_des_exist);
    end
  end

  // compare every cycle once reset has been seen
  always @(negedge clk) begin
    if (model_on) begin
      chk("ex_exist",  {31'b0, ex_des_exist},  {31'b0, m_ex.e});
      chk("ex_addr",   {27'b0, ex_des_addr},   {27'b0, m_ex.a});
      chk("ex_data",   ex_des_data,            m_ex.d);
      chk("mem_exist", {31'b0, mem_des_exist}, {31'b0, m_mem.e});
      chk("mem_addr",  {27'b0, mem_des_addr},  {27'b0, m_mem.a});
      chk("mem_data",  mem_des_data,           m_mem.d);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr, input logic ex);
    alu_op = op; alu_sel = sel; id_src1 = a; id_src2 = b;
    id_des_addr = addr; id_des_exist = ex;
  endtask

  task automatic idle();
    drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ex(input string name, input logic e, input logic [4:0] a,
                        input logic [31:0] d);
    chk({name, "_ex_exist"}, {31'b0, ex_des_exist}, {31'b0, e});
    chk({name, "_ex_addr"},  {27'b0, ex_des_addr},  {27'b0, a});
    chk({name, "_ex_data"},  ex_des_data, d);
  endtask

  task automatic chk_mem(input string name, input logic e, input logic [4:0] a,
                         input logic [31:0] d);
    chk({name, "_mem_exist"}, {31'b0, mem_des_exist}, {31'b0, e});
    chk({name, "_mem_addr"},  {27'b0, mem_des_addr},  {27'b0, a});
    chk({name, "_mem_data"},  mem_des_data, d);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    cyc();
    chk_ex("reset", 1'b0, 5'd0, 32'h0);
    chk_mem("reset", 1'b0, 5'd0, 32'h0);
    rst = 1'b0;

    // or: latency 1 to ex, 2 to mem
    drive(8'h25, 3'b001, 32'h0000_FF00, 32'h0F0F_0F0F, 5'd3, 1'b1);
    cyc();
    chk_ex("or", 1'b1, 5'd3, 32'h0F0F_FF0F);
    idle();
    cyc();
    chk_mem("or", 1'b1, 5'd3, 32'h0F0F_FF0F);

    drive(8'h03, 3'b010, 32'd4, 32'h8000_0010, 5'd6, 1'b1);
    cyc();
    chk("sra", ex_des_data, 32'hF800_0001);
    drive(8'h02, 3'b010, 32'd4, 32'h8000_0010, 5'd6, 1'b1);
    cyc();
    chk("srl", ex_des_data, 32'h0800_0001);
    drive(8'h7C, 3'b010, 32'h0000_0020, 32'h1234_5678, 5'd6, 1'b1);
    cyc();
    chk("sll0", ex_des_data, 32'h1234_5678);
    drive(8'h27, 3'b001, 32'h0, 32'h0, 5'd7, 1'b1);
    cyc();
    chk("nor", ex_des_data, 32'hFFFF_FFFF);
    // sllv arrives with sel=logic but still shifts
    drive(8'h7C, 3'b001, 32'd8, 32'h0000_00AB, 5'd8, 1'b1);
    cyc();
    chk_ex("sllv", 1'b1, 5'd8, 32'h0000_AB00);
    // unknown op: zero result, exist passes
    drive(8'h55, 3'b001, 32'h1, 32'h2, 5'd9, 1'b1);
    cyc();
    chk_ex("unk", 1'b1, 5'd9, 32'h0);
    // sel nop: zero result, no write
    drive(8'h25, 3'b000, 32'h1, 32'h2, 5'd10, 1'b1);
    cyc();
    chk_ex("selnop", 1'b0, 5'd10, 32'h0);
    // r0 write suppressed
    drive(8'h25, 3'b001, 32'h1, 32'h2, 5'd0, 1'b1);
    cyc();
    chk("r0_ex_exist", {31'b0, ex_des_exist}, 32'h0);
    idle();
    cyc();
    chk("r0_mem_exist", {31'b0, mem_des_exist}, 32'h0);

    // stall: A in cycle 0, stall in cycles 1-2
    drive(8'h26, 3'b001, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd4, 1'b1);
    cyc();
    chk_ex("stall_c1", 1'b1, 5'd4, 32'hF0F0_0F0F);
    stall = 1'b1;
    drive(8'h24, 3'b001, 32'h1111_1111, 32'h2222_2222, 5'd12, 1'b1);
    cyc();
    chk_ex("stall_c2", 1'b1, 5'd4, 32'hF0F0_0F0F);
    chk("stall_c2_mem_exist", {31'b0, mem_des_exist}, 32'h0);
    cyc();
    chk_ex("stall_c3", 1'b1, 5'd4, 32'hF0F0_0F0F);
    chk("stall_c3_mem_exist", {31'b0, mem_des_exist}, 32'h0);
    stall = 1'b0;
    idle();
    cyc();
    chk_mem("stall_c4", 1'b1, 5'd4, 32'hF0F0_0F0F);

    // flush and stall together: flush wins
    drive(8'h24, 3'b001, 32'hFF00_FF00, 32'hF0F0_F0F0, 5'd5, 1'b1);
    cyc();
    chk_ex("pre_flush", 1'b1, 5'd5, 32'hF000_F000);
    flush = 1'b1; stall = 1'b1;
    cyc();
    chk_ex("flush", 1'b0, 5'd0, 32'h0);
    chk_mem("flush", 1'b0, 5'd0, 32'h0);
    flush = 1'b0; stall = 1'b0;

    // reset mid-stream, with stall also high
    drive(8'h25, 3'b001, 32'h1, 32'h2, 5'd11, 1'b1);
    cyc();
    drive(8'h26, 3'b001, 32'h3, 32'h5, 5'd13, 1'b1);
    cyc();
    chk_mem("pre_rst", 1'b1, 5'd11, 32'h3);
    rst = 1'b1; stall = 1'b1;
    cyc();
    chk_ex("rst_mid", 1'b0, 5'd0, 32'h0);
    chk_mem("rst_mid", 1'b0, 5'd0, 32'h0);
    rst = 1'b0; stall = 1'b0;
    drive(8'h03, 3'b010, 32'd31, 32'h8000_0000, 5'd14, 1'b1);
    cyc();
    chk_ex("refill", 1'b1, 5'd14, 32'hFFFF_FFFF);
    idle();
    cyc();
    chk_mem("refill", 1'b1, 5'd14, 32'hFFFF_FFFF);
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
